// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Optional saturating statistics counters are enabled by defining BP_STATS_EN.
module branch_predictor #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pc_fetch,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_next_pc,
    input  logic            upd_valid,
    input  logic            upd_is_br,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_pred_taken,
    input  logic [XLEN-1:0] upd_pred_pc,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     stat_updates,
    output logic [31:0]     stat_mispredicts
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    logic            r_valid  [ENTRIES];
    logic [1:0]      r_ctr    [ENTRIES];
    logic [TAG_W-1:0] r_tag   [ENTRIES];
    logic [XLEN-1:0] r_target [ENTRIES];

    logic [IDX_W-1:0] w_f_idx;
    logic [TAG_W-1:0] w_f_tag;
    logic [IDX_W-1:0] w_u_idx;
    logic [TAG_W-1:0] w_u_tag;
    logic             w_u_hit;
    logic             w_tbl_we;
    logic             w_tgt_we;
    logic             w_alloc;
    logic [1:0]       w_ctr_cur;
    logic [1:0]       w_ctr_next;

    // Lookup sees registered table contents only; same-cycle updates are not bypassed.
    assign w_f_idx      = pc_fetch[IDX_W+1:2];
    assign w_f_tag      = pc_fetch[XLEN-1:IDX_W+2];
    assign pred_hit     = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
    assign pred_taken   = pred_hit && r_ctr[w_f_idx][1];
    assign pred_next_pc = pred_taken ? r_target[w_f_idx] : pc_fetch + XLEN'(4);

    assign mispredict  = upd_valid && (upd_taken ? (upd_pred_pc != upd_target) : upd_pred_taken);
    assign redirect_pc = upd_taken ? upd_target : upd_pc + XLEN'(4);

    assign w_u_idx   = upd_pc[IDX_W+1:2];
    assign w_u_tag   = upd_pc[XLEN-1:IDX_W+2];
    assign w_u_hit   = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);
    assign w_ctr_cur = r_ctr[w_u_idx];
    assign w_tbl_we  = upd_valid && (w_u_hit || upd_taken);
    assign w_tgt_we  = upd_valid && (upd_taken || (w_u_hit && !upd_is_br));
    assign w_alloc   = upd_valid && !w_u_hit && upd_taken;

    always_comb begin
        w_ctr_next = w_ctr_cur;
        if (!w_u_hit) begin
            w_ctr_next = upd_is_br ? 2'b10 : 2'b11;
        end else if (!upd_is_br) begin
            w_ctr_next = 2'b11;
        end else if (upd_taken && (w_ctr_cur != 2'b11)) begin
            w_ctr_next = w_ctr_cur + 2'd1;
        end else if (!upd_taken && (w_ctr_cur != 2'b00)) begin
            w_ctr_next = w_ctr_cur - 2'd1;
        end
    end

    // Valid and counter state per entry carry the reset; tag and target never need it.
    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid[gi] <= 1'b0;
                    r_ctr[gi]   <= 2'b01;
                end else if (w_tbl_we && (w_u_idx == IDX_W'(gi))) begin
                    r_valid[gi] <= 1'b1;
                    r_ctr[gi]   <= w_ctr_next;
                end
            end

            always_ff @(posedge clk) begin
                if (w_alloc && (w_u_idx == IDX_W'(gi))) begin
                    r_tag[gi] <= w_u_tag;
                end
                if (w_tgt_we && (w_u_idx == IDX_W'(gi))) begin
                    r_target[gi] <= upd_target;
                end
            end
        end
    endgenerate

`ifdef BP_STATS_EN
    logic [31:0] r_stat_upd;
    logic [31:0] r_stat_mis;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_upd <= '0;
            r_stat_mis <= '0;
        end else begin
            if (upd_valid && (r_stat_upd != 32'hFFFF_FFFF)) begin
                r_stat_upd <= r_stat_upd + 32'd1;
            end
            if (mispredict && (r_stat_mis != 32'hFFFF_FFFF)) begin
                r_stat_mis <= r_stat_mis + 32'd1;
            end
        end
    end

    assign stat_updates     = r_stat_upd;
    assign stat_mispredicts = r_stat_mis;
`else
    assign stat_updates     = '0;
    assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed vector bench for branch_predictor (ENTRIES=16, XLEN=32).
module tb_branch_predictor;
    logic        clk;
    logic        rst_n;
    logic [31:0] pc_fetch;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_next_pc;
    logic        upd_valid;
    logic        upd_is_br;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_pc;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] stat_updates;
    logic [31:0] stat_mispredicts;

    int n_checks;
    int n_fail;

    branch_predictor #(.XLEN(32), .ENTRIES(16)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pc_fetch         (pc_fetch),
        .pred_hit         (pred_hit),
        .pred_taken       (pred_taken),
        .pred_next_pc     (pred_next_pc),
        .upd_valid        (upd_valid),
        .upd_is_br        (upd_is_br),
        .upd_pc           (upd_pc),
        .upd_taken        (upd_taken),
        .upd_target       (upd_target),
        .upd_pred_taken   (upd_pred_taken),
        .upd_pred_pc      (upd_pred_pc),
        .mispredict       (mispredict),
        .redirect_pc      (redirect_pc),
        .stat_updates     (stat_updates),
        .stat_mispredicts (stat_mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        uv;
        logic        br;
        logic [31:0] upc;
        logic        tk;
        logic [31:0] tgt;
        logic        upt;
        logic [31:0] uppc;
        logic [31:0] fpc;
        logic        e_hit;
        logic        e_taken;
        logic [31:0] e_npc;
        logic        e_mis;
        logic [31:0] e_red;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic uv, input logic br, input logic [31:0] upc, input logic tk,
                       input logic [31:0] tgt, input logic upt, input logic [31:0] uppc,
                       input logic [31:0] fpc, input logic e_hit, input logic e_taken,
                       input logic [31:0] e_npc, input logic e_mis, input logic [31:0] e_red);
        vec_t v;
        v.uv = uv; v.br = br; v.upc = upc; v.tk = tk; v.tgt = tgt; v.upt = upt; v.uppc = uppc;
        v.fpc = fpc; v.e_hit = e_hit; v.e_taken = e_taken; v.e_npc = e_npc;
        v.e_mis = e_mis; v.e_red = e_red;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec=%0d actual=0x%08h required=0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic drive_idle(input logic [31:0] fpc);
        upd_valid = 1'b0; upd_is_br = 1'b0; upd_pc = '0; upd_taken = 1'b0;
        upd_target = '0; upd_pred_taken = 1'b0; upd_pred_pc = '0; pc_fetch = fpc;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        drive_idle(32'h100);

        //   uv br upc          tk tgt           upt uppc         fpc          hit tk npc          mis red
        add(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h100,     0, 0, 32'h104,      0, 32'h4);   // 0 cold miss
        add(1, 1, 32'h100,      1, 32'h200,      0, 32'h104,      32'h100,     0, 0, 32'h104,      1, 32'h200); // 1 alloc, ctr 10
        add(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h100,     1, 1, 32'h200,      0, 32'h4);   // 2 now hit
        add(1, 1, 32'h100,      1, 32'h200,      1, 32'h200,      32'h100,     1, 1, 32'h200,      0, 32'h200); // 3 ctr 11
        add(1, 1, 32'h100,      1, 32'h200,      1, 32'h200,      32'h100,     1, 1, 32'h200,      0, 32'h200); // 4 ctr holds 11
        add(1, 1, 32'h100,      0, 32'h200,      1, 32'h200,      32'h100,     1, 1, 32'h200,      1, 32'h104); // 5 NT -> 10
        add(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h100,     1, 1, 32'h200,      0, 32'h4);   // 6 still taken
        add(1, 1, 32'h100,      0, 32'h200,      1, 32'h200,      32'h100,     1, 1, 32'h200,      1, 32'h104); // 7 NT -> 01
        add(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h100,     1, 0, 32'h104,      0, 32'h4);   // 8 predicts NT
        add(1, 1, 32'h100,      0, 32'h200,      0, 32'h104,      32'h100,     1, 0, 32'h104,      0, 32'h104); // 9 -> 00
        add(1, 1, 32'h100,      0, 32'h200,      0, 32'h104,      32'h100,     1, 0, 32'h104,      0, 32'h104); // 10 holds 00
        add(1, 1, 32'h100,      1, 32'h280,      0, 32'h104,      32'h100,     1, 0, 32'h104,      1, 32'h280); // 11 -> 01, tgt 280
        add(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h100,     1, 0, 32'h104,      0, 32'h4);   // 12 still NT
        add(1, 1, 32'h100,      1, 32'h280,      0, 32'h104,      32'h100,     1, 0, 32'h104,      1, 32'h280); // 13 -> 10
        add(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h100,     1, 1, 32'h280,      0, 32'h4);   // 14 new target
        add(1, 1, 32'h140,      1, 32'h500,      0, 32'h144,      32'h140,     0, 0, 32'h144,      1, 32'h500); // 15 alias alloc
        add(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h100,     0, 0, 32'h104,      0, 32'h4);   // 16 victim gone
        add(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h140,     1, 1, 32'h500,      0, 32'h4);   // 17 alias hit
        add(1, 0, 32'h140,      1, 32'h600,      1, 32'h500,      32'h140,     1, 1, 32'h500,      1, 32'h600); // 18 jump hit, wrong tgt
        add(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h140,     1, 1, 32'h600,      0, 32'h4);   // 19 jump tgt updated
        add(1, 0, 32'h208,      1, 32'h40,       0, 32'h20C,      32'h208,     0, 0, 32'h20C,      1, 32'h40);  // 20 jump alloc ctr 11
        add(1, 1, 32'h208,      0, 32'h40,       1, 32'h40,       32'h208,     1, 1, 32'h40,       1, 32'h20C); // 21 -> 10
        add(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h208,     1, 1, 32'h40,       0, 32'h4);   // 22 still taken
        add(1, 1, 32'h30C,      0, 32'h0,        0, 32'h310,      32'h30C,     0, 0, 32'h310,      0, 32'h310); // 23 miss NT no alloc
        add(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h30C,     0, 0, 32'h310,      0, 32'h4);   // 24 still miss
        add(1, 1, 32'h300,      1, 32'h700,      0, 32'h304,      32'h300,     0, 0, 32'h304,      1, 32'h700); // 25 same-cycle: no bypass
        add(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h300,     1, 1, 32'h700,      0, 32'h4);   // 26 visible next cycle
        add(1, 1, 32'hFFFFFFFC, 0, 32'h0,        0, 32'h0,        32'hFFFFFFFC,0, 0, 32'h0,        0, 32'h0);   // 27 pc+4 wraps
        add(0, 1, 32'h300,      1, 32'h900,      0, 32'h100,      32'h300,     1, 1, 32'h700,      0, 32'h900); // 28 no update when !valid
        add(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h300,     1, 1, 32'h700,      0, 32'h4);   // 29 table unchanged

        // Reset state while rst_n is held low
        #12;
        check("rst_hit",   -1, 32'(pred_hit),   32'h0);
        check("rst_taken", -1, 32'(pred_taken), 32'h0);
        check("rst_npc",   -1, pred_next_pc,    32'h104);
        check("rst_stu",   -1, stat_updates,    32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            upd_valid = vecs[i].uv; upd_is_br = vecs[i].br; upd_pc = vecs[i].upc;
            upd_taken = vecs[i].tk; upd_target = vecs[i].tgt; upd_pred_taken = vecs[i].upt;
            upd_pred_pc = vecs[i].uppc; pc_fetch = vecs[i].fpc;
            #2;
            check("pred_hit",     i, 32'(pred_hit),   32'(vecs[i].e_hit));
            check("pred_taken",   i, 32'(pred_taken), 32'(vecs[i].e_taken));
            check("pred_next_pc", i, pred_next_pc,    vecs[i].e_npc);
            check("mispredict",   i, 32'(mispredict), 32'(vecs[i].e_mis));
            check("redirect_pc",  i, redirect_pc,     vecs[i].e_red);
            $display("vec %0d: fpc=0x%08h hit=%0d taken=%0d npc=0x%08h mis=%0d red=0x%08h",
                     i, pc_fetch, pred_hit, pred_taken, pred_next_pc, mispredict, redirect_pc);
        end

        @(negedge clk);
        drive_idle(32'h300);
        #2;
`ifdef BP_STATS_EN
        check("stat_updates",     -1, stat_updates,     32'd16);
        check("stat_mispredicts", -1, stat_mispredicts, 32'd10);
`else
        check("stat_updates",     -1, stat_updates,     32'd0);
        check("stat_mispredicts", -1, stat_mispredicts, 32'd0);
`endif

        // Asynchronous reset mid-cycle with an update pending on the inputs
        upd_valid = 1'b1; upd_is_br = 1'b1; upd_pc = 32'h300; upd_taken = 1'b1;
        upd_target = 32'hA00; upd_pred_taken = 1'b1; upd_pred_pc = 32'h700;
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_stu",  -1, stat_updates,     32'd0);
        check("arst_stm",  -1, stat_mispredicts, 32'd0);
        check("arst_hit",  -1, 32'(pred_hit),    32'h0);
        check("arst_npc",  -1, pred_next_pc,     32'h304);
        check("arst_mis",  -1, 32'(mispredict),  32'h1);
        check("arst_red",  -1, redirect_pc,      32'hA00);
        @(negedge clk);
        drive_idle(32'h100);
        rst_n = 1'b1;
        #2;
        check("post_rst_hit_100", -1, 32'(pred_hit), 32'h0);
        pc_fetch = 32'h140;
        #1;
        check("post_rst_hit_140", -1, 32'(pred_hit), 32'h0);
        pc_fetch = 32'h208;
        #1;
        check("post_rst_hit_208", -1, 32'(pred_hit), 32'h0);
        $display("reset mid-run: stats=%0d/%0d hit=%0d", stat_updates, stat_mispredicts, pred_hit);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
